// File: rtl/hazard_idex_stage.sv
// -----------------------------------------------------------------------------
// hazard_idex_stage
//
// ID/EX pipeline register for the SIMD AES pipeline with integrated load-use
// hazard detection. Decoded operands and controls are captured from ID into
// EX_* one cycle later. When the instruction in ID reads the destination of a
// load sitting in EX, LOAD_LAT bubbles are inserted. While they are inserted,
// the PC and IF/ID are frozen. A taken branch (flush) kills the ID
// instruction. An external memory stall (ext_stall) freezes the whole front
// end.
//
// Handshake: this stage has no valid/ready pair. ID_valid qualifies the ID
// slot. PC_Write and IF_ID_Write are the only back-pressure to the front end.
// When either is 0, upstream must hold the ID_* inputs steady for that edge.
//
// Parameters:
//   DATA_W   operand width (vector width; scalars are zero-extended upstream)
//   REG_AW   register index width
//   IMM_W    immediate width
//   ALUOP_W  ALU operation code width
//   LOAD_LAT bubbles inserted per load-use hazard (1..7)
//
// Ports:
//   clk, rst_n                 rising-edge clock; asynchronous active-low reset
//   ID_*                       decoded instruction, operands and controls from ID
//   flush                      branch taken; kill the ID instruction
//   ext_stall                  memory busy; freeze the front end
//   EX_*                       registered instruction presented to EX / forwarding
//   PC_Write, IF_ID_Write      front-end enables (combinational)
//   stall_active               high while a load-use stall is in progress
//   dbg_state                  FSM state for checkers (1 = STALL)
//   perf_stall_cycles          (HAZARD_PERF_CNT_EN only) load-use bubble count
//   perf_flush_cnt             (HAZARD_PERF_CNT_EN only) flush count
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the saturating perf counters.
// -----------------------------------------------------------------------------
module hazard_idex_stage #(
  parameter int DATA_W   = 128,
  parameter int REG_AW   = 5,
  parameter int IMM_W    = 32,
  parameter int ALUOP_W  = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ID_valid,
  input  logic [REG_AW-1:0]  ID_rs1,
  input  logic [REG_AW-1:0]  ID_rs2,
  input  logic [REG_AW-1:0]  ID_rd,
  input  logic               ID_uses_rs1,
  input  logic               ID_uses_rs2,
  input  logic               ID_RegWrite,
  input  logic               ID_VRegWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_MemWrite,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [IMM_W-1:0]   ID_Imm,
  input  logic               flush,
  input  logic               ext_stall,
  output logic               EX_valid,
  output logic               EX_RegWrite,
  output logic               EX_VRegWrite,
  output logic               EX_MemToReg,
  output logic               EX_MemWrite,
  output logic [REG_AW-1:0]  EX_rs1,
  output logic [REG_AW-1:0]  EX_rs2,
  output logic [REG_AW-1:0]  EX_rd,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [IMM_W-1:0]   EX_Imm,
  output logic               PC_Write,
  output logic               IF_ID_Write,
  output logic               stall_active,
  output logic               dbg_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flush_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;

  logic               r_ex_valid;
  logic               r_ex_regwrite;
  logic               r_ex_vregwrite;
  logic               r_ex_memtoreg;
  logic               r_ex_memwrite;
  logic [REG_AW-1:0]  r_ex_rs1;
  logic [REG_AW-1:0]  r_ex_rs2;
  logic [REG_AW-1:0]  r_ex_rd;
  logic [ALUOP_W-1:0] r_ex_aluop;
  logic [DATA_W-1:0]  r_ex_rd1;
  logic [DATA_W-1:0]  r_ex_rd2;
  logic [IMM_W-1:0]   r_ex_imm;

  logic w_hz;
  logic w_bubble;     // load a bubble into EX this edge
  logic w_lu_bubble;  // bubble caused by a load-use stall (not by flush)
  logic w_capture;    // capture ID into EX this edge
  logic w_stall_active;

  // Index 0 is deliberately not special-cased: a load to x0 still stalls.
  assign w_hz = ID_valid & r_ex_valid & r_ex_memtoreg &
                (r_ex_regwrite | r_ex_vregwrite) &
                ((ID_uses_rs1 & (ID_rs1 == r_ex_rd)) |
                 (ID_uses_rs2 & (ID_rs2 == r_ex_rd)));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and per-edge action, highest priority first:
  // flush, ext_stall, ongoing stall / new hazard, then normal capture.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bubble    = 1'b0;
    w_lu_bubble = 1'b0;
    w_capture   = 1'b0;
    if (flush) begin
      w_bubble    = 1'b1;
      w_state_nxt = IDLE;
      w_cnt_nxt   = 3'd0;
    end else if (ext_stall) begin
      // Everything holds.
    end else if (r_state == STALL) begin
      // hz is not re-evaluated here; EX already holds a bubble.
      w_bubble    = 1'b1;
      w_lu_bubble = 1'b1;
      if (r_cnt == 3'd1) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 3'd0;
      end else begin
        w_cnt_nxt   = r_cnt - 3'd1;
      end
    end else if (w_hz) begin
      w_bubble    = 1'b1;
      w_lu_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        w_state_nxt = STALL;
        w_cnt_nxt   = 3'(LOAD_LAT - 1);
      end
    end else begin
      w_capture = 1'b1;
    end
  end

  assign w_stall_active = (r_state == STALL) | ((r_state == IDLE) & w_hz & ~flush);

  // flush overrides every freeze so the redirected PC is taken immediately.
  assign PC_Write     = ~(w_stall_active | ext_stall) | flush;
  assign IF_ID_Write  = ~(w_stall_active | ext_stall) | flush;
  assign stall_active = w_stall_active;
  assign dbg_state    = (r_state == STALL);

  // ---------------------------------------------------------------------------
  // ID/EX register. A bubble clears valid and every control, including ALUOp.
  // Indices, operands and the immediate hold their previous contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_vregwrite <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_aluop     <= '0;
      r_ex_rd1       <= '0;
      r_ex_rd2       <= '0;
      r_ex_imm       <= '0;
    end else if (w_bubble) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_vregwrite <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_aluop     <= '0;
    end else if (w_capture) begin
      r_ex_valid     <= ID_valid;
      r_ex_regwrite  <= ID_RegWrite;
      r_ex_vregwrite <= ID_VRegWrite;
      r_ex_memtoreg  <= ID_MemToReg;
      r_ex_memwrite  <= ID_MemWrite;
      r_ex_rs1       <= ID_rs1;
      r_ex_rs2       <= ID_rs2;
      r_ex_rd        <= ID_rd;
      r_ex_aluop     <= ID_ALUOp;
      r_ex_rd1       <= ID_ReadData1;
      r_ex_rd2       <= ID_ReadData2;
      r_ex_imm       <= ID_Imm;
    end
  end

  assign EX_valid     = r_ex_valid;
  assign EX_RegWrite  = r_ex_regwrite;
  assign EX_VRegWrite = r_ex_vregwrite;
  assign EX_MemToReg  = r_ex_memtoreg;
  assign EX_MemWrite  = r_ex_memwrite;
  assign EX_rs1       = r_ex_rs1;
  assign EX_rs2       = r_ex_rs2;
  assign EX_rd        = r_ex_rd;
  assign EX_ALUOp     = r_ex_aluop;
  assign EX_ReadData1 = r_ex_rd1;
  assign EX_ReadData2 = r_ex_rd2;
  assign EX_Imm       = r_ex_imm;

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (w_lu_bubble && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_cnt    = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_idex_stage.sv
// -----------------------------------------------------------------------------
// tb_hazard_idex_stage
//
// Two instances of hazard_idex_stage share one stimulus stream:
// instance 0 uses LOAD_LAT=1 and instance 1 uses LOAD_LAT=3.
// The reference model tracks the EX slot contents plus a "bubble debt" count
// per instance. Directed scenarios pin the model with literal expectations.
// A randomized phase then exercises hazards, flush and ext_stall against the
// model.
// -----------------------------------------------------------------------------
module tb_hazard_idex_stage;

  localparam logic [127:0] DEADBEEF = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT inputs ----------------
  logic         i_valid, i_u1, i_u2, i_rw, i_vrw, i_m2r, i_mw, i_flush, i_ext;
  logic [4:0]   i_rs1, i_rs2, i_rd;
  logic [3:0]   i_alu;
  logic [127:0] i_d1, i_d2;
  logic [31:0]  i_imm;

  // ---------------- DUT outputs (index = instance) ----------------
  logic         o_valid[2], o_rw[2], o_vrw[2], o_m2r[2], o_mw[2];
  logic [4:0]   o_rs1[2], o_rs2[2], o_rd[2];
  logic [3:0]   o_alu[2];
  logic [127:0] o_d1[2], o_d2[2];
  logic [31:0]  o_imm[2];
  logic         o_pcw[2], o_ifw[2], o_stall[2], o_dbg[2];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]  o_pst[2], o_pfl[2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_idex_stage #(
      .DATA_W(128), .REG_AW(5), .IMM_W(32), .ALUOP_W(4),
      .LOAD_LAT((g == 0) ? 1 : 3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ID_valid(i_valid), .ID_rs1(i_rs1), .ID_rs2(i_rs2), .ID_rd(i_rd),
      .ID_uses_rs1(i_u1), .ID_uses_rs2(i_u2),
      .ID_RegWrite(i_rw), .ID_VRegWrite(i_vrw), .ID_MemToReg(i_m2r), .ID_MemWrite(i_mw),
      .ID_ALUOp(i_alu), .ID_ReadData1(i_d1), .ID_ReadData2(i_d2), .ID_Imm(i_imm),
      .flush(i_flush), .ext_stall(i_ext),
      .EX_valid(o_valid[g]), .EX_RegWrite(o_rw[g]), .EX_VRegWrite(o_vrw[g]),
      .EX_MemToReg(o_m2r[g]), .EX_MemWrite(o_mw[g]),
      .EX_rs1(o_rs1[g]), .EX_rs2(o_rs2[g]), .EX_rd(o_rd[g]), .EX_ALUOp(o_alu[g]),
      .EX_ReadData1(o_d1[g]), .EX_ReadData2(o_d2[g]), .EX_Imm(o_imm[g]),
      .PC_Write(o_pcw[g]), .IF_ID_Write(o_ifw[g]), .stall_active(o_stall[g]),
      .dbg_state(o_dbg[g])
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cycles(o_pst[g]), .perf_flush_cnt(o_pfl[g])
`endif
    );
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic         valid, rw, vrw, m2r, mw;
    logic [3:0]   alu;
    logic [4:0]   rs1, rs2, rd;
    logic [127:0] d1, d2;
    logic [31:0]  imm;
  } ex_t;

  ex_t         m_ex[2];
  int          m_debt[2];      // bubbles still owed after the current edge
  logic [31:0] m_pst[2], m_pfl[2];
  int          lat[2] = '{1, 3};

  int total = 0;
  int bad   = 0;

  function automatic bit model_hz(int k);
    return i_valid && m_ex[k].valid && m_ex[k].m2r && (m_ex[k].rw || m_ex[k].vrw) &&
           ((i_u1 && i_rs1 == m_ex[k].rd) || (i_u2 && i_rs2 == m_ex[k].rd));
  endfunction

  function automatic ex_t id_word();
    ex_t e;
    e.valid = i_valid; e.rw = i_rw; e.vrw = i_vrw; e.m2r = i_m2r; e.mw = i_mw;
    e.alu = i_alu; e.rs1 = i_rs1; e.rs2 = i_rs2; e.rd = i_rd;
    e.d1 = i_d1; e.d2 = i_d2; e.imm = i_imm;
    return e;
  endfunction

  function automatic ex_t bubble_of(ex_t e);
    ex_t b;
    b = e;
    b.valid = 1'b0; b.rw = 1'b0; b.vrw = 1'b0; b.m2r = 1'b0; b.mw = 1'b0; b.alu = 4'd0;
    return b;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ex[k]   <= '0;
        m_debt[k] <= 0;
        m_pst[k]  <= 32'd0;
        m_pfl[k]  <= 32'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (i_flush) begin
          m_ex[k]   <= bubble_of(m_ex[k]);
          m_debt[k] <= 0;
          m_pfl[k]  <= sat_inc(m_pfl[k]);
        end else if (i_ext) begin
          m_ex[k] <= m_ex[k];
        end else if (m_debt[k] > 0) begin
          m_ex[k]   <= bubble_of(m_ex[k]);
          m_debt[k] <= m_debt[k] - 1;
          m_pst[k]  <= sat_inc(m_pst[k]);
        end else if (model_hz(k)) begin
          m_ex[k]   <= bubble_of(m_ex[k]);
          m_debt[k] <= lat[k] - 1;
          m_pst[k]  <= sat_inc(m_pst[k]);
        end else begin
          m_ex[k] <= id_word();
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int k, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lat%0d t=%0t got=%0h want=%0h", nm, lat[k], $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        logic e_stall, e_pcw;
        e_stall = (m_debt[k] > 0) || (model_hz(k) && !i_flush);
        e_pcw   = !(e_stall || i_ext) || i_flush;
        chk("stall_active", k, o_stall[k], e_stall);
        chk("pc_write",     k, o_pcw[k],   e_pcw);
        chk("if_id_write",  k, o_ifw[k],   e_pcw);
        chk("dbg_state",    k, o_dbg[k],   m_debt[k] > 0);
        chk("ex_valid",     k, o_valid[k], m_ex[k].valid);
        chk("ex_ctl",       k, {o_rw[k], o_vrw[k], o_m2r[k], o_mw[k]},
            {m_ex[k].rw, m_ex[k].vrw, m_ex[k].m2r, m_ex[k].mw});
        if (m_ex[k].valid) begin
          chk("ex_idx",  k, {o_rs1[k], o_rs2[k], o_rd[k], o_alu[k]},
              {m_ex[k].rs1, m_ex[k].rs2, m_ex[k].rd, m_ex[k].alu});
          chk("ex_d1",   k, o_d1[k],  m_ex[k].d1);
          chk("ex_d2",   k, o_d2[k],  m_ex[k].d2);
          chk("ex_imm",  k, o_imm[k], m_ex[k].imm);
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", k, o_pst[k], m_pst[k]);
        chk("perf_flush", k, o_pfl[k], m_pfl[k]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_in();
    i_valid = 0; i_u1 = 0; i_u2 = 0; i_rw = 0; i_vrw = 0; i_m2r = 0; i_mw = 0;
    i_flush = 0; i_ext = 0; i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_alu = 0;
    i_d1 = 0; i_d2 = 0; i_imm = 0;
  endtask

  task automatic put(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic u1, input logic u2, input logic rw, input logic vrw,
                     input logic m2r);
    i_valid = 1; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_u1 = u1; i_u2 = u2;
    i_rw = rw; i_vrw = vrw; i_m2r = m2r; i_mw = 0;
    i_alu = 4'($urandom_range(0, 15));
    i_d1 = {$urandom, $urandom, $urandom, $urandom};
    i_d2 = {$urandom, $urandom, $urandom, $urandom};
    i_imm = $urandom; i_flush = 0; i_ext = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic settle();
    clr_in();
    repeat (4) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_in();
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, o_valid[k], 0);
      chk("rst_d1",    k, o_d1[k], 0);
      chk("rst_pcw",   k, o_pcw[k], 1);
      chk("rst_stall", k, o_stall[k], 0);
    end
    @(negedge clk); rst_n = 1;

    // Load x5 then add rs1=5, LOAD_LAT=1: one bubble.
    tick(); put(0, 0, 5, 0, 0, 1, 0, 1);
    tick(); put(5, 0, 6, 1, 0, 1, 0, 0);
    mid();  chk("t1_pcw0", 0, o_pcw[0], 0); chk("t1_stall0", 0, o_stall[0], 1);
    tick(); mid();
    chk("t1_bubble", 0, o_valid[0], 0); chk("t1_pcw1", 0, o_pcw[0], 1);
    tick(); mid();
    chk("t1_valid", 0, o_valid[0], 1); chk("t1_rs1", 0, o_rs1[0], 5);
    settle();

    // Vector load v7 then vxor rs2=7, LOAD_LAT=3: three bubbles.
    tick(); put(0, 0, 7, 0, 0, 0, 1, 1);
    tick(); put(0, 7, 8, 0, 1, 0, 1, 0);
    mid();  chk("t2_stall_a", 1, o_stall[1], 1);
    tick(); mid(); chk("t2_bub1", 1, o_valid[1], 0); chk("t2_stall_b", 1, o_stall[1], 1);
    tick(); mid(); chk("t2_bub2", 1, o_valid[1], 0); chk("t2_stall_c", 1, o_stall[1], 1);
    tick(); mid(); chk("t2_bub3", 1, o_valid[1], 0); chk("t2_stall_d", 1, o_stall[1], 0);
    chk("t2_pcw", 1, o_pcw[1], 1);
    tick(); mid(); chk("t2_valid", 1, o_valid[1], 1); chk("t2_rs2", 1, o_rs2[1], 7);
    settle();

    // Matching index but not actually read: no bubble.
    tick(); put(0, 0, 5, 0, 0, 1, 0, 1);
    tick(); put(5, 9, 10, 0, 0, 1, 0, 0);
    mid();  chk("t3_stall0", 0, o_stall[0], 0); chk("t3_stall1", 1, o_stall[1], 0);
    chk("t3_pcw", 0, o_pcw[0], 1);
    tick(); mid(); chk("t3_valid", 0, o_valid[0], 1); chk("t3_rs1", 0, o_rs1[0], 5);
    settle();

    // Flush in the 2nd cycle of a LOAD_LAT=3 stall.
    tick(); put(0, 0, 5, 0, 0, 1, 0, 1);
    tick(); put(5, 0, 6, 1, 0, 1, 0, 0);
    tick(); i_flush = 1;
    mid();  chk("t4_pcw_fl", 1, o_pcw[1], 1); chk("t4_install", 1, o_dbg[1], 1);
    tick(); i_flush = 0;
    mid();  chk("t4_valid", 1, o_valid[1], 0); chk("t4_idle", 1, o_dbg[1], 0);
    chk("t4_pcw", 1, o_pcw[1], 1);
    settle();

    // ext_stall holds EX for 4 cycles, then flush with ext_stall loads a bubble.
    tick(); put(1, 2, 3, 0, 0, 1, 0, 0); i_d1 = DEADBEEF;
    tick(); put(4, 4, 4, 1, 1, 1, 0, 0); i_ext = 1;
    for (int c = 0; c < 4; c++) begin
      mid();
      for (int k = 0; k < 2; k++) begin
        chk("t5_hold_d1", k, o_d1[k], DEADBEEF);
        chk("t5_pcw", k, o_pcw[k], 0);
      end
      if (c < 3) tick();
    end
    i_flush = 1; #1;
    chk("t5_pcw_fl", 0, o_pcw[0], 1);
    tick(); i_flush = 0; i_ext = 0;
    mid();  chk("t5_bub0", 0, o_valid[0], 0); chk("t5_bub1", 1, o_valid[1], 0);
    settle();

    // Asynchronous reset mid-stall.
    tick(); put(0, 0, 5, 0, 0, 1, 0, 1);
    tick(); put(5, 0, 6, 1, 0, 1, 0, 0);
    tick(); #3; rst_n = 0; #1;
    for (int k = 0; k < 2; k++) begin
      chk("t6_valid", k, o_valid[k], 0);
      chk("t6_d1",    k, o_d1[k], 0);
      chk("t6_rs1",   k, o_rs1[k], 0);
      chk("t6_stall", k, o_stall[k], 0);
      chk("t6_pcw",   k, o_pcw[k], 1);
`ifdef HAZARD_PERF_CNT_EN
      chk("t6_pst", k, o_pst[k], 0);
      chk("t6_pfl", k, o_pfl[k], 0);
`endif
    end
    @(negedge clk); rst_n = 1;
    settle();

    // Randomized phase: small register space so hazards are frequent.
    for (int n = 0; n < 2000; n++) begin
      tick();
      i_valid = ($urandom_range(0, 9) < 8);
      i_rs1   = 5'($urandom_range(0, 3));
      i_rs2   = 5'($urandom_range(0, 3));
      i_rd    = 5'($urandom_range(0, 3));
      i_u1    = 1'($urandom_range(0, 1));
      i_u2    = 1'($urandom_range(0, 1));
      i_rw    = 1'($urandom_range(0, 1));
      i_vrw   = 1'($urandom_range(0, 1));
      i_m2r   = ($urandom_range(0, 9) < 4);
      i_mw    = 1'($urandom_range(0, 1));
      i_alu   = 4'($urandom_range(0, 15));
      i_d1    = {$urandom, $urandom, $urandom, $urandom};
      i_d2    = {$urandom, $urandom, $urandom, $urandom};
      i_imm   = $urandom;
      i_flush = ($urandom_range(0, 19) == 0);
      i_ext   = ($urandom_range(0, 9) == 0);
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_idex_stage.md
Name: hazard_idex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the SIMD AES pipeline.
- Captures decoded operands and control from ID and presents EX_rs1/EX_rs2/EX_rd plus write-enable and MemToReg controls to the EX stage and forwarding logic.
- Inserts bubbles and freezes PC and IF/ID on load-use hazards.
- Handles branch flush and external memory stall.

Parameters:
- DATA_W, 128, operand width; vector width, scalar zero-extended upstream.
- REG_AW, 5, register index width.
- IMM_W, 32, immediate width.
- ALUOP_W, 4, ALU operation code width.
- LOAD_LAT, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ID_valid  in  1  ID holds a real instruction.
- ID_rs1, ID_rs2, ID_rd  in  REG_AW  source and destination indices.
- ID_uses_rs1, ID_uses_rs2  in  1  instruction actually reads rs1/rs2.
- ID_RegWrite, ID_VRegWrite, ID_MemToReg, ID_MemWrite  in  1  decoded controls.
- ID_ALUOp  in  ALUOP_W  ALU operation.
- ID_ReadData1, ID_ReadData2  in  DATA_W  register-file read data.
- ID_Imm  in  IMM_W  immediate.
- flush  in  1  branch taken; kill the ID instruction.
- ext_stall  in  1  memory busy; freeze whole front end.
- EX_valid, EX_RegWrite, EX_VRegWrite, EX_MemToReg, EX_MemWrite  out  1  registered controls.
- EX_rs1, EX_rs2, EX_rd  out  REG_AW  registered indices.
- EX_ALUOp  out  ALUOP_W  registered ALU op.
- EX_ReadData1, EX_ReadData2  out  DATA_W  registered operands.
- EX_Imm  out  IMM_W  registered immediate.
- PC_Write, IF_ID_Write  out  1  front-end enables; combinational.
- stall_active  out  1  high while a load-use stall is in progress.

Behaviour:
- Reset is asynchronous, active-low:
  - All EX_* registers go to 0.
  - FSM goes to IDLE and the bubble counter to 0.
  - PC_Write=IF_ID_Write=1 and stall_active=0 follow combinationally.
- Hazard term, combinational:
  - hz = ID_valid & EX_valid & EX_MemToReg & (EX_RegWrite|EX_VRegWrite) & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)).
  - Index 0 is not special-cased.
- FSM states are IDLE and STALL; cnt is 3 bits.
- Per-edge priority, highest first:
  1. flush: load a bubble (EX_valid and all EX controls 0; data/index registers don't-care, implemented as hold). FSM goes to IDLE, cnt=0. Flush overrides ext_stall and any in-progress stall.
  2. ext_stall: all EX registers, FSM and cnt hold. PC_Write=IF_ID_Write=0.
  3. IDLE & hz: load a bubble, PC_Write=IF_ID_Write=0. If LOAD_LAT==1 stay IDLE; otherwise go to STALL with cnt=LOAD_LAT-1.
  4. STALL: load a bubble, PC_Write=IF_ID_Write=0, cnt decrements. When cnt reaches 1, return to IDLE on this edge.
  5. Otherwise: capture all ID_* into EX_*, with EX_valid=ID_valid.
- In STALL, hz is not re-evaluated; EX holds bubbles by construction.
- stall_active = (state==STALL) | (state==IDLE & hz & ~flush).
- PC_Write = IF_ID_Write = ~(stall_active | ext_stall) | flush.
- Latency: one cycle from ID to EX; a load-use pair is separated by exactly LOAD_LAT bubbles.
- With ID_valid=0, EX_valid=0 is captured and no hazard can fire.
- Reset mid-stall aborts the stall immediately; no bubble debt is retained.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cycles increments on each edge where a load-use bubble is inserted (priority item 3 or 4).
  - perf_flush_cnt increments on each edge with flush=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load x5, then add rs1=5, LOAD_LAT=1 → exactly one cycle with EX_valid=0. PC_Write=0 for that cycle only. The add reaches EX on the next edge with EX_rs1=5.
- LOAD_LAT=3, vector load v7, then vxor rs2=7 → 3 consecutive bubbles and stall_active high for 3 cycles, then vxor captured.
- Load x5, then an instruction with ID_uses_rs1=0, ID_rs1=5 → no bubble, captured next edge.
- Flush asserted in the 2nd cycle of a LOAD_LAT=3 stall → next edge EX_valid=0, FSM in IDLE, PC_Write=1 that cycle.
- ext_stall held 4 cycles with data 128'hDEAD…BEEF in EX → EX_* unchanged, PC_Write=0. Then flush together with ext_stall → bubble loaded.
- rst_n pulled low mid-stall, asynchronously between edges → all EX_* immediately 0, stall_active=0, PC_Write=1. With the macro on, perf counters read 0.
